// File: rtl/ime_pkg.sv
// Shared definitions for the multi-reference IME top: FSM encoding and width helpers.
package ime_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_CMP,
    S_PUSH
  } state_t;

  // Reference-index width: max(1, clog2(ref_num_max)).
  function automatic int ri_len(input int ref_num_max);
    return (ref_num_max <= 2) ? 1 : $clog2(ref_num_max);
  endfunction

  // FIFO entry layout, MSB to LSB: {mvd[32*imvd_len], mb_type[mbt_len], ref_idx[ri]}.
  function automatic int ent_w(input int imvd_len, input int mbt_len, input int ri);
    return 32 * imvd_len + mbt_len + ri;
  endfunction

endpackage

// File: rtl/ime_res_fifo.sv
// Result FIFO toward FME: registered storage, head shown combinationally, push+pop when full allowed.
module ime_res_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][W-1:0] mem;
  logic [AW-1:0]           wr_ptr, rd_ptr;
  logic [AW:0]             cnt;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign rd_data = mem[rd_ptr];

  // Power-of-two depth makes the natural pointer overflow the wrap.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      if (wr_en && !rd_en)      cnt <= cnt + (AW+1)'(1);
      else if (!wr_en && rd_en) cnt <= cnt - (AW+1)'(1);
    end
  end

endmodule

// File: rtl/ime_mref_top.sv
// Multi-reference IME top: runs the search engine once per reference, keeps the cheapest pass.
// Optional reference-index cost bias is enabled with `define IME_MREF_BIAS_EN.
module ime_mref_top
  import ime_pkg::*;
#(
  parameter int  REF_NUM_MAX = 4,
  parameter int  IMVD_LEN    = 10,
  parameter int  COST_LEN    = 16,
  parameter int  MBT_LEN     = 10,
  parameter int  FIFO_DEPTH  = 2,
  localparam int RI_LEN      = ri_len(REF_NUM_MAX)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  sysif_start_i,
  input  logic [RI_LEN:0]       sysif_ref_num_i,
  input  logic [8:0]            sysif_lambda_i,
  output logic                  sysif_done_o,
  output logic                  eng_start_o,
  output logic [RI_LEN-1:0]     eng_ref_idx_o,
  input  logic                  eng_done_i,
  input  logic [COST_LEN-1:0]   eng_cost_i,
  input  logic [32*IMVD_LEN-1:0] eng_mvd_i,
  input  logic [MBT_LEN-1:0]    eng_mb_type_i,
  output logic                  fmeif_valid_o,
  input  logic                  fmeif_ready_i,
  output logic [32*IMVD_LEN-1:0] fmeif_imv_o,
  output logic [MBT_LEN-1:0]    fmeif_mb_type_o,
  output logic [RI_LEN-1:0]     fmeif_ref_idx_o
);

  localparam int MVW = 32 * IMVD_LEN;
  localparam int EW  = ent_w(IMVD_LEN, MBT_LEN, RI_LEN);

  state_t              state, nxt;
  logic [RI_LEN:0]     n_ref, ref_num_clamped;
  logic [RI_LEN-1:0]   ref_cnt, best_ref;
  logic [COST_LEN-1:0] cap_cost, best_cost, eff_cost;
  logic [MVW-1:0]      cap_mvd, best_mvd;
  logic [MBT_LEN-1:0]  cap_mbt, best_mbt;
  logic                last, win, push, pop, fifo_full, fifo_empty;
  logic [EW-1:0]       head;

  always_comb begin
    ref_num_clamped = sysif_ref_num_i;
    if (sysif_ref_num_i == '0)
      ref_num_clamped = (RI_LEN+1)'(1);
    else if (sysif_ref_num_i > (RI_LEN+1)'(REF_NUM_MAX))
      ref_num_clamped = (RI_LEN+1)'(REF_NUM_MAX);
  end

`ifdef IME_MREF_BIAS_EN
  localparam int BW = COST_LEN + RI_LEN + 9;
  logic [BW-1:0] biased;
  assign biased   = BW'(cap_cost) + BW'(ref_cnt) * BW'(sysif_lambda_i);
  assign eff_cost = (|biased[BW-1:COST_LEN]) ? '1 : biased[COST_LEN-1:0];
`else
  logic unused_lambda;
  assign unused_lambda = ^sysif_lambda_i;
  assign eff_cost      = cap_cost;
`endif

  assign last = ({1'b0, ref_cnt} == n_ref - (RI_LEN+1)'(1));
  // Pass 0 always seeds the best slot so a saturated cost still yields a defined winner.
  assign win  = (ref_cnt == '0) || (eff_cost < best_cost);
  assign pop  = fmeif_valid_o & fmeif_ready_i;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt         = state;
    eng_start_o = 1'b0;
    push        = 1'b0;
    case (state)
      S_IDLE:   if (sysif_start_i) nxt = S_LAUNCH;
      S_LAUNCH: begin
        eng_start_o = 1'b1;
        nxt         = S_WAIT;
      end
      S_WAIT:   if (eng_done_i) nxt = S_CMP;
      S_CMP:    nxt = last ? S_PUSH : S_LAUNCH;
      S_PUSH:   if (!fifo_full || pop) begin
        push = 1'b1;
        nxt  = S_IDLE;
      end
      default:  nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      n_ref     <= '0;
      ref_cnt   <= '0;
      cap_cost  <= '0;
      cap_mvd   <= '0;
      cap_mbt   <= '0;
      best_cost <= '1;
      best_mvd  <= '0;
      best_mbt  <= '0;
      best_ref  <= '0;
    end else begin
      case (state)
        S_IDLE: if (sysif_start_i) begin
          n_ref     <= ref_num_clamped;
          ref_cnt   <= '0;
          best_cost <= '1;
        end
        S_WAIT: if (eng_done_i) begin
          cap_cost <= eng_cost_i;
          cap_mvd  <= eng_mvd_i;
          cap_mbt  <= eng_mb_type_i;
        end
        S_CMP: begin
          if (win) begin
            best_cost <= eff_cost;
            best_mvd  <= cap_mvd;
            best_mbt  <= cap_mbt;
            best_ref  <= ref_cnt;
          end
          if (!last) ref_cnt <= ref_cnt + RI_LEN'(1);
        end
        default: ;
      endcase
    end
  end

  assign sysif_done_o  = push;
  assign eng_ref_idx_o = ref_cnt;
  assign fmeif_valid_o = ~fifo_empty;
  assign {fmeif_imv_o, fmeif_mb_type_o, fmeif_ref_idx_o} = head;

  ime_res_fifo #(.W(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .wr_en   (push),
    .wr_data ({best_mvd, best_mbt, best_ref}),
    .rd_en   (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

endmodule

// File: tb/tb_ime_mref_top.sv
// Scoreboard bench for ime_mref_top: engine model, random backpressure, reference winner model.
module tb_ime_mref_top;

  localparam int RNM = 4, IMVD = 10, CL = 16, MBT = 10, DEP = 2, RI = 2;
  localparam int MVW = 32 * IMVD, EW = MVW + MBT + RI;

  logic           clk = 1'b0, rstn = 1'b0;
  logic           sysif_start_i = 1'b0;
  logic [RI:0]    sysif_ref_num_i = '0;
  logic [8:0]     sysif_lambda_i = '0;
  logic           sysif_done_o, eng_start_o;
  logic [RI-1:0]  eng_ref_idx_o;
  logic           eng_done_i = 1'b0;
  logic [CL-1:0]  eng_cost_i = '0;
  logic [MVW-1:0] eng_mvd_i = '0;
  logic [MBT-1:0] eng_mb_type_i = '0;
  logic           fmeif_valid_o, fmeif_ready_i = 1'b0;
  logic [MVW-1:0] fmeif_imv_o;
  logic [MBT-1:0] fmeif_mb_type_o;
  logic [RI-1:0]  fmeif_ref_idx_o;

  int cmp_cnt = 0, err_cnt = 0, st_cnt = 0, dn_cnt = 0, rmode = 0;
  logic [EW-1:0] exp_q[$];

  ime_mref_top #(.REF_NUM_MAX(RNM), .IMVD_LEN(IMVD), .COST_LEN(CL), .MBT_LEN(MBT),
                 .FIFO_DEPTH(DEP)) dut (
    .clk(clk), .rstn(rstn), .sysif_start_i(sysif_start_i), .sysif_ref_num_i(sysif_ref_num_i),
    .sysif_lambda_i(sysif_lambda_i), .sysif_done_o(sysif_done_o), .eng_start_o(eng_start_o),
    .eng_ref_idx_o(eng_ref_idx_o), .eng_done_i(eng_done_i), .eng_cost_i(eng_cost_i),
    .eng_mvd_i(eng_mvd_i), .eng_mb_type_i(eng_mb_type_i), .fmeif_valid_o(fmeif_valid_o),
    .fmeif_ready_i(fmeif_ready_i), .fmeif_imv_o(fmeif_imv_o), .fmeif_mb_type_o(fmeif_mb_type_o),
    .fmeif_ref_idx_o(fmeif_ref_idx_o));

  always #5 clk = ~clk;

  // rmode: 0 random ready, 1 held low, 2 held high
  always @(posedge clk) begin
    #1;
    case (rmode)
      0:       fmeif_ready_i = ($urandom % 4) != 0;
      1:       fmeif_ready_i = 1'b0;
      default: fmeif_ready_i = 1'b1;
    endcase
  end

  always @(negedge clk) begin
    if (rstn) begin
      if (eng_start_o)  st_cnt = st_cnt + 1;
      if (sysif_done_o) dn_cnt = dn_cnt + 1;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_done"},     64'(sysif_done_o), 0);
    chk({tag, "_start"},    64'(eng_start_o), 0);
    chk({tag, "_eref"},     64'(eng_ref_idx_o), 0);
    chk({tag, "_valid"},    64'(fmeif_valid_o), 0);
    chk({tag, "_imv_or"},   64'(|fmeif_imv_o), 0);
    chk({tag, "_mbt"},      64'(fmeif_mb_type_o), 0);
    chk({tag, "_fref"},     64'(fmeif_ref_idx_o), 0);
  endtask

  function automatic logic [MVW-1:0] rand_mvd();
    logic [MVW-1:0] r;
    for (int i = 0; i < MVW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Waits for eng_start_o, sampled on falling edges; lat = falling edges skipped.
  task automatic wait_start(output bit ok, output int lat);
    ok = 1'b0;
    lat = 0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (eng_start_o) begin
        ok = 1'b1;
        lat = t;
        break;
      end
    end
    if (!ok) begin
      cmp_cnt++;
      err_cnt++;
      $display("FAIL eng_start_timeout: got no pulse expected pulse within 100 cycles");
    end
  endtask

  task automatic drive_done(input int cost, input logic [MVW-1:0] mv, input logic [MBT-1:0] mt);
    eng_done_i = 1'b1;
    eng_cost_i = CL'(cost);
    eng_mvd_i = mv;
    eng_mb_type_i = mt;
    @(posedge clk); #1;
    eng_done_i = 1'b0;
    eng_cost_i = CL'($urandom);
    eng_mvd_i = rand_mvd();
  endtask

  task automatic run_mb(input int rn, input int c0, input int c1, input int c2, input int c3,
                        input int lam, input bit stall, input bit poke);
    int cost[4];
    logic [MVW-1:0] mv[4];
    logic [MBT-1:0] mt[4];
    int n, win, best, eff, st0, dn0, lat, t;
    bit ok;
    cost = '{c0, c1, c2, c3};
    n = (rn == 0) ? 1 : ((rn > RNM) ? RNM : rn);
    win = 0;
    best = 0;
    for (int i = 0; i < n; i++) begin
      mv[i] = rand_mvd();
      mt[i] = MBT'($urandom);
`ifdef IME_MREF_BIAS_EN
      eff = cost[i] + i * lam;
      if (eff > 65535) eff = 65535;
`else
      eff = cost[i];
`endif
      if (i == 0 || eff < best) begin
        best = eff;
        win = i;
      end
    end
    exp_q.push_back({mv[win], mt[win], RI'(win)});
    st0 = st_cnt;
    dn0 = dn_cnt;
    @(posedge clk); #1;
    sysif_start_i = 1'b1;
    sysif_ref_num_i = 3'(rn);
    sysif_lambda_i = 9'(lam);
    @(posedge clk); #1;
    sysif_start_i = 1'b0;
    for (int i = 0; i < n; i++) begin
      wait_start(ok, lat);
      if (!ok) return;
      chk("launch_gap", 64'(lat), (i == 0) ? 0 : 1);
      chk("eng_ref_idx", 64'(eng_ref_idx_o), 64'(i));
      repeat (1 + $urandom_range(0, 4)) @(posedge clk);
      #1;
      if (poke && i == 0) begin
        sysif_start_i = 1'b1;
        @(posedge clk); #1;
        sysif_start_i = 1'b0;
      end
      drive_done(cost[i], mv[i], mt[i]);
    end
    if (stall) begin
      repeat (12) @(posedge clk);
      chk("stall_no_done", 64'(dn_cnt - dn0), 0);
    end else begin
      t = 0;
      while (dn_cnt == dn0 && t < 60) begin
        @(posedge clk);
        t++;
      end
      chk("done_pulse", 64'(dn_cnt - dn0), 1);
    end
    chk("start_pulses", 64'(st_cnt - st0), 64'(n));
  endtask

  task automatic drain();
    rmode = 2;
    for (int t = 0; t < 200; t++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
    end
    repeat (2) @(posedge clk);
    chk("drained", 64'(exp_q.size()), 0);
    chk("drained_valid", 64'(fmeif_valid_o), 0);
  endtask

  initial begin
    fork
      begin : main
        bit ok;
        int lat, t, st0, dn0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_zero("reset");
        @(posedge clk); #1;
        rstn = 1'b1;

        run_mb(3, 500, 300, 400, 0, 0, 1'b0, 1'b0);
        run_mb(0, 700, 0, 0, 0, 0, 1'b0, 1'b0);
        run_mb(7, 900, 800, 700, 600, 0, 1'b0, 1'b0);
        run_mb(2, 200, 200, 0, 0, 0, 1'b0, 1'b0);
`ifdef IME_MREF_BIAS_EN
        run_mb(2, 200, 195, 0, 0, 10, 1'b0, 1'b0);
`endif
        run_mb(2, 300, 100, 0, 0, 0, 1'b0, 1'b1);
        drain();

        rmode = 1;
        repeat (2) @(posedge clk);
        run_mb(1, 10, 0, 0, 0, 0, 1'b0, 1'b0);
        run_mb(2, 50, 40, 0, 0, 0, 1'b0, 1'b0);
        run_mb(3, 9, 8, 7, 0, 0, 1'b1, 1'b0);
        @(negedge clk);
        chk("full_valid", 64'(fmeif_valid_o), 1);
        rmode = 2;
        ok = 1'b0;
        for (t = 0; t < 20; t++) begin
          @(negedge clk);
          if (sysif_done_o) begin
            ok = 1'b1;
            break;
          end
        end
        chk("third_done_seen", 64'(ok), 1);
        chk("push_pop_same_cycle", 64'(fmeif_valid_o && fmeif_ready_i), 1);
        drain();

        st0 = st_cnt;
        dn0 = dn_cnt;
        @(posedge clk); #1;
        drive_done(0, rand_mvd(), '0);
        repeat (5) @(posedge clk);
        chk("stray_done_starts", 64'(st_cnt - st0), 0);
        chk("stray_done_dones", 64'(dn_cnt - dn0), 0);
        chk("stray_done_valid", 64'(fmeif_valid_o), 0);

        @(posedge clk); #1;
        sysif_start_i = 1'b1;
        sysif_ref_num_i = 3'd3;
        @(posedge clk); #1;
        sysif_start_i = 1'b0;
        wait_start(ok, lat);
        @(posedge clk); #1;
        drive_done(5, rand_mvd(), '0);
        wait_start(ok, lat);
        @(posedge clk); #1;
        rstn = 1'b0;
        @(negedge clk);
        chk_zero("abort");
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        repeat (3) @(posedge clk);
        chk("abort_no_entry", 64'(fmeif_valid_o), 0);
        run_mb(2, 60, 70, 0, 0, 0, 1'b0, 1'b0);
        drain();

        rmode = 0;
        for (int k = 0; k < 25; k++) begin
          run_mb($urandom_range(0, 7),
                 ($urandom % 8 == 0) ? 65535 : $urandom_range(0, 5) * 100,
                 $urandom_range(0, 5) * 100, $urandom_range(0, 5) * 100,
                 ($urandom % 2) ? $urandom_range(0, 65535) : $urandom_range(0, 5) * 100,
                 $urandom_range(0, 511), 1'b0, 1'b0);
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
      end
      begin : monitor
        logic [EW-1:0] act, exp;
        forever begin
          @(negedge clk);
          if (rstn && fmeif_valid_o && fmeif_ready_i) begin
            act = {fmeif_imv_o, fmeif_mb_type_o, fmeif_ref_idx_o};
            cmp_cnt++;
            if (exp_q.size() == 0) begin
              err_cnt++;
              $display("FAIL fifo_head: got entry ref_idx=%0d expected no entry", fmeif_ref_idx_o);
            end else begin
              exp = exp_q.pop_front();
              if (act !== exp) begin
                err_cnt++;
                $display("FAIL fifo_head: got ref_idx=%0d mbt=%0h imv_lo=%0h expected ref_idx=%0d mbt=%0h imv_lo=%0h",
                         act[RI-1:0], act[RI +: MBT], act[RI+MBT +: 32],
                         exp[RI-1:0], exp[RI +: MBT], exp[RI+MBT +: 32]);
              end
            end
          end
        end
      end
    join_any
  end

endmodule

// File: doc/ime_mref_top.md
# ime_mref_top

Multi-reference successor to the single-reference IME top. It sequences up to `REF_NUM_MAX` reference frames through the existing IME search engine for one macroblock. For each pass it keeps the lowest-cost result and tags it with its reference index. The winner is queued in a small FIFO toward FME, under a valid/ready handshake rather than a free-running valid.

## Interface
- `REF_NUM_MAX`, 4: maximum reference frames per MB; must be ≥1.
- `IMVD_LEN`, 10: width of one MV component.
- `COST_LEN`, 16: width of the engine cost.
- `MBT_LEN`, 10: combined mb_type + 4×sub_mb_type width.
- `FIFO_DEPTH`, 2: result buffer entries; power of two, ≥2.
- `RI_LEN` is derived: `max(1, clog2(REF_NUM_MAX))`.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `sysif_start_i`  in  1  one-cycle pulse that starts the MB.
- `sysif_ref_num_i`  in  RI_LEN+1  number of references for this MB.
- `sysif_lambda_i`  in  9  lambda for the reference-index bias.
- `sysif_done_o`  out  1  one-cycle pulse when the MB result is enqueued.
- `eng_start_o`  out  1  one-cycle pulse that starts one engine pass.
- `eng_ref_idx_o`  out  RI_LEN  reference index of the current pass.
- `eng_done_i`  in  1  one-cycle pulse; engine result is valid this cycle.
- `eng_cost_i`  in  COST_LEN  best cost of the pass.
- `eng_mvd_i`  in  32×IMVD_LEN  16 MV pairs.
- `eng_mb_type_i`  in  MBT_LEN  partition type of the pass.
- `fmeif_valid_o`  out  1  FIFO head is valid.
- `fmeif_ready_i`  in  1  FME accepts the head.
- `fmeif_imv_o`  out  32×IMVD_LEN  MVs at the FIFO head.
- `fmeif_mb_type_o`  out  MBT_LEN  partition type at the FIFO head.
- `fmeif_ref_idx_o`  out  RI_LEN  reference index at the FIFO head.

## Operation
- FSM states: IDLE, LAUNCH, WAIT, CMP, PUSH.
- IDLE → LAUNCH on `sysif_start_i`.
  - Latch `n_ref = clamp(sysif_ref_num_i, 1, REF_NUM_MAX)`; a value of 0 is treated as 1.
  - Clear `ref_cnt`; set best cost to all-ones.
- LAUNCH: assert `eng_start_o` for one cycle with `eng_ref_idx_o = ref_cnt`, then go to WAIT.
- WAIT: hold until `eng_done_i`, then capture the engine result and go to CMP.
- CMP: compute the effective cost, defined below.
  - Replace the best result if effective cost < best cost (strict). Ties keep the lower index.
  - If `ref_cnt == n_ref-1`, go to PUSH; otherwise increment `ref_cnt` and go to LAUNCH.
- PUSH: when the FIFO is not full, write {mvd, mb_type, ref_idx}, pulse `sysif_done_o`, and go to IDLE.
  - When the FIFO is full, stall in PUSH without a pulse.
- `sysif_start_i` outside IDLE is ignored.
- `eng_done_i` outside WAIT is ignored.
- FIFO:
  - `fmeif_valid_o` = not empty; outputs show the head entry combinationally from registered storage.
  - Pop when `valid & ready`.
  - A push and pop in the same cycle are both honoured, including when the FIFO is full (pop frees the slot).
  - Pointers wrap modulo `FIFO_DEPTH`.
- Reset: FSM to IDLE, FIFO emptied, counters zero.
- Reset values of outputs: `sysif_done_o` 0, `eng_start_o` 0, `eng_ref_idx_o` 0, `fmeif_valid_o` 0, `fmeif_imv_o` 0, `fmeif_mb_type_o` 0, `fmeif_ref_idx_o` 0.
- Reset mid-operation aborts the MB; nothing is enqueued.

## Timing
- `eng_start_o` rises one cycle after `sysif_start_i`.
- CMP takes one cycle, and the next LAUNCH follows the cycle after.
- Per-reference overhead is 3 cycles plus engine latency.
- `sysif_done_o` fires one cycle after the final CMP when the FIFO is not full.
- The FIFO entry is visible on `fmeif_valid_o` in the cycle following the push cycle.
- `fmeif_valid_o` is registered. Ready-to-valid carries no combinational path.

## Configuration
- `IME_MREF_BIAS_EN` defined:
  - effective cost = `eng_cost_i + ref_idx × sysif_lambda_i`;
  - computed at COST_LEN+RI_LEN+9 bits, then saturated to COST_LEN all-ones.
- `IME_MREF_BIAS_EN` undefined: effective cost = `eng_cost_i`. `sysif_lambda_i` is unused.

## Structure
- Shared package `ime_pkg`:
  - FSM state encoding;
  - `RI_LEN` derivation function;
  - the FIFO entry struct/width constant (mvd, mb_type, ref_idx).
- One sub-module, `ime_res_fifo`: parametrised width/depth synchronous FIFO with full/empty and registered storage. The top holds the FSM and the compare logic.

## Test plan
- `REF_NUM_MAX=4`, ref_num=3, costs 500/300/400, bias off → one FIFO entry with ref_idx=1 and that pass's mvd; 3 `eng_start_o` pulses; `sysif_done_o` once.
- ref_num=0 → exactly 1 pass, ref_idx=0. ref_num=7 → clamped to 4 passes.
- Costs 200/200 → ref_idx=0 (tie keeps the lower index). With the bias on and λ=10, costs 200/195 → ref_idx=0 (205 > 200).
- `fmeif_ready_i` held 0 over 3 MBs (DEPTH=2) → 2 entries held and the third MB stalls in PUSH with no done. Raise ready → push and pop in the same cycle, then the third done pulse, and entries drain in order.
- `sysif_start_i` and a stray `eng_done_i` during WAIT → no state change.
- `rstn` low during WAIT → all outputs 0; FIFO empty; a later start runs normally.
